text_vram_arbiter: RTL and testbench
====================================

// Module: text_vram_arbiter
// PURPOSE
//  Shares one single-port, synchronous-read text VRAM (char+attr per cell) between the display
//  fetch path and a host write port. Display fetch has absolute priority and fixed latency.
//  Host writes are buffered in a small FIFO and drained into cycles with no display request.
//  Sits between the video timing controller/char fetcher and the VRAM.
// PARAMETERS
//  ADDR_W      12    VRAM address width (cell index)
//  DATA_W      16    cell width: [15:8] attribute, [7:0] char code
//  CELLS       2400  valid cells (80x30); addresses >= CELLS are out of range
//  FIFO_DEPTH  4     host write FIFO entries (power of 2, >= 2)
// PORTS
//  pixel_clk    in   1          clock, all logic on posedge
//  reset        in   1          synchronous, active-high
//  en           in   1          0: no RAM accesses issued, FIFO and pipeline hold state
//  blank        in   1          1 while timing controller is outside the active area
//  disp_req     in   1          display read request, 1-cycle pulse
//  disp_addr    in   ADDR_W     display read address
//  disp_rvalid  out  1          disp_rdata valid, 1-cycle pulse
//  disp_rdata   out  DATA_W     display read data
//  host_valid   in   1          host write request
//  host_ready   out  1          FIFO can accept; write accepted when valid&ready
//  host_addr    in   ADDR_W     host write address
//  host_wdata   in   DATA_W     host write data
//  host_drop    out  1          1-cycle pulse: accepted write was out of range, discarded
//  fifo_level   out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  ram_addr     out  ADDR_W     registered VRAM address
//  ram_we       out  1          registered VRAM write enable
//  ram_wdata    out  DATA_W     registered VRAM write data
//  ram_rdata    in   DATA_W     VRAM read data, valid 1 cycle after ram_addr
// BEHAVIOUR
//  - Reset: FIFO emptied, fifo_level=0, host_ready=0 during reset then 1; ram_we=0, ram_addr=0,
//    ram_wdata=0, disp_rvalid=0, disp_rdata=0, host_drop=0. In-flight display reads cancelled.
//  - Display: disp_req sampled at edge k (en=1) -> ram_addr=disp_addr, ram_we=0 from edge k;
//    disp_rdata<=ram_rdata and disp_rvalid=1 after edge k+2. Latency exactly 2, never stalled;
//    back-to-back requests every cycle give back-to-back rvalid.
//  - Host accept: host_ready = !full (registered occupancy only; a same-cycle pop does not free a
//    slot). On accept with host_addr >= CELLS: entry not pushed, host_drop pulses next cycle.
//  - Drain: in a cycle with en=1, disp_req=0, FIFO non-empty (and drain gate open, see
//    CONFIGURATION): pop head, ram_addr/ram_wdata=head, ram_we=1 for one cycle. Max one write/cycle.
//  - Simultaneous push+pop on non-full FIFO: level unchanged, order preserved (strict FIFO).
//  - Idle cycle (no disp_req, nothing to drain): ram_we=0, ram_addr holds previous value.
//  - en=0: ram_we=0, no pop; disp_req ignored (no rvalid generated); host may still push until full;
//    pending rvalid pipeline stages still complete.
//  - Pointers wrap modulo FIFO_DEPTH; level saturates never (full blocks push).
//  - disp_req while en=1 always wins over a pending write; writes wait, never dropped.
// CONFIGURATION
//  TEXT_VRAM_BLANK_WR_EN defined: drain gate = blank; host writes enter VRAM only while blank=1
//    (tear-free updates); FIFO holds writes during active video.
//  Not defined: drain gate always open; writes fill any free cycle regardless of blank.
// TESTING
//  1 Reset, then disp_req@addr 5 with VRAM[5]=16'h1F41 -> disp_rvalid exactly 2 cycles later,
//    disp_rdata=16'h1F41; fifo_level=0.
//  2 Host writes 0x0010<=16'h0748 with disp_req=0 -> ram_we=1, ram_addr=0x010, ram_wdata=0748;
//    later disp read of 0x010 returns 16'h0748.
//  3 disp_req held high 10 cycles while host pushes 5 writes -> host_ready=0 after 4 accepted,
//    no ram_we during the 10 cycles, 4 writes drain in order on the 4 cycles after.
//  4 Host write to addr 2400 -> host_drop pulse, fifo_level unchanged, no ram_we.
//  5 With TEXT_VRAM_BLANK_WR_EN, blank=0, 2 writes queued -> no ram_we; blank=1 -> both drain
//    on consecutive cycles. Without macro -> drain immediately.
//  6 Reset asserted with 3 queued writes and one read in flight -> no ram_we, no disp_rvalid after,
//    fifo_level=0.

Source files
------------

// File: rtl/text_vram_arbiter.sv
// text_vram_arbiter: shares one single-port text VRAM between a fixed-latency display fetch and a FIFO-buffered host write port.
// Optional macro TEXT_VRAM_BLANK_WR_EN restricts host write draining to blanking intervals.
`default_nettype none

module text_vram_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int CELLS      = 2400,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            pixel_clk,
  input  logic                            reset,
  input  logic                            en,
  input  logic                            blank,
  input  logic                            disp_req,
  input  logic [ADDR_W-1:0]               disp_addr,
  output logic                            disp_rvalid,
  output logic [DATA_W-1:0]               disp_rdata,
  input  logic                            host_valid,
  output logic                            host_ready,
  input  logic [ADDR_W-1:0]               host_addr,
  input  logic [DATA_W-1:0]               host_wdata,
  output logic                            host_drop,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [ADDR_W-1:0]               ram_addr,
  output logic                            ram_we,
  output logic [DATA_W-1:0]               ram_wdata,
  input  logic [DATA_W-1:0]               ram_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              rd_s1;
  logic              rd_s2;

  logic full;
  logic empty;
  logic accept;
  logic in_range;
  logic do_push;
  logic do_pop;
  logic do_read;
  logic drain_gate;

`ifdef TEXT_VRAM_BLANK_WR_EN
  assign drain_gate = blank;
`else
  // Gate permanently open; blank is OR-ed in only so the port is not left dangling.
  assign drain_gate = blank | 1'b1;
`endif

  // Readiness reflects registered occupancy only, so a pop in the same cycle never frees a slot early.
  assign full       = (level == LVL_W'(FIFO_DEPTH));
  assign empty      = (level == '0);
  assign host_ready = !reset && !full;
  assign accept     = host_valid && host_ready;
  assign in_range   = (32'(host_addr) < CELLS);
  assign do_push    = accept && in_range;
  assign do_read    = en && disp_req;
  assign do_pop     = en && !disp_req && !empty && drain_gate;
  assign fifo_level = level;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_wdata   <= '0;
      rd_s1       <= 1'b0;
      rd_s2       <= 1'b0;
      disp_rvalid <= 1'b0;
      disp_rdata  <= '0;
      host_drop   <= 1'b0;
    end else begin
      ram_we <= do_pop;
      if (do_read) begin
        ram_addr <= disp_addr;
      end else if (do_pop) begin
        ram_addr  <= fifo_addr[rd_ptr];
        ram_wdata <= fifo_data[rd_ptr];
      end

      // Read pipeline advances even with en=0 so in-flight fetches always complete.
      rd_s1       <= do_read;
      rd_s2       <= rd_s1;
      disp_rvalid <= rd_s2;
      if (rd_s2) disp_rdata <= ram_rdata;

      host_drop <= accept && !in_range;

      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (do_push) begin
      fifo_addr[wr_ptr] <= host_addr;
      fifo_data[wr_ptr] <= host_wdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_text_vram_arbiter.sv
// tb_text_vram_arbiter: directed table, corner sequences and random traffic against a queue-based model.
`default_nettype none

module tb_text_vram_arbiter;

  localparam int DEPTH = 4;
  localparam int CELLS = 2400;

  logic        pixel_clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        blank = 1'b0;
  logic        disp_req = 1'b0;
  logic [11:0] disp_addr = '0;
  logic        disp_rvalid;
  logic [15:0] disp_rdata;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [11:0] host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        host_drop;
  logic [2:0]  fifo_level;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = '0;

  text_vram_arbiter dut (
    .pixel_clk(pixel_clk), .reset(reset), .en(en), .blank(blank),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_drop(host_drop), .fifo_level(fifo_level),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Synchronous single-port VRAM
  logic [15:0] mem [4096];
  always @(posedge pixel_clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Reference model: VRAM contents as seen by host, pending-write queue, scheduled read returns
  typedef struct { logic [11:0] a; logic [15:0] d; } wr_t;
  typedef struct { int due; logic [15:0] d; } rd_t;
  wr_t         q[$];
  rd_t         rq[$];
  logic [15:0] model_mem [4096];
  int          cyc = 0;
  logic        e_we = 0, e_rvalid = 0, e_drop = 0;
  logic [11:0] e_addr = 0;
  logic [15:0] e_wdata = 0, e_rdata = 0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    cyc++;
    if (reset) begin
      q.delete();
      rq.delete();
      e_we = 0; e_addr = 0; e_wdata = 0; e_rvalid = 0; e_rdata = 0; e_drop = 0;
    end else begin
      bit acc, rd, gate, pop;
      acc = host_valid && (q.size() < DEPTH);
      rd  = en && disp_req;
`ifdef TEXT_VRAM_BLANK_WR_EN
      gate = blank;
`else
      gate = 1'b1;
`endif
      pop = en && !disp_req && (q.size() != 0) && gate;
      e_rvalid = 0;
      if (rq.size() != 0 && rq[0].due == cyc) begin
        e_rvalid = 1;
        e_rdata  = rq[0].d;
        void'(rq.pop_front());
      end
      e_we = pop;
      if (pop) begin
        wr_t h;
        h = q.pop_front();
        model_mem[h.a] = h.d;
        e_addr  = h.a;
        e_wdata = h.d;
      end else if (rd) begin
        e_addr = disp_addr;
      end
      if (rd) rq.push_back('{cyc + 2, model_mem[disp_addr]});
      e_drop = acc && (32'(host_addr) >= CELLS);
      if (acc && 32'(host_addr) < CELLS) q.push_back('{host_addr, host_wdata});
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    model_step();
    #1;
    chk("ram_we", ram_we, e_we);
    chk("ram_addr", ram_addr, e_addr);
    chk("ram_wdata", ram_wdata, e_wdata);
    chk("disp_rvalid", disp_rvalid, e_rvalid);
    chk("disp_rdata", disp_rdata, e_rdata);
    chk("host_drop", host_drop, e_drop);
    chk("fifo_level", fifo_level, q.size());
    chk("host_ready", host_ready, !reset && (q.size() < DEPTH));
  endtask

  typedef struct {
    logic en, req; logic [11:0] daddr;
    logic hv; logic [11:0] haddr; logic [15:0] hdata;
    logic we; logic [11:0] addr; logic [15:0] wdata;
    logic rvalid; logic [15:0] rdata; int level; logic drop;
  } vec_t;

  vec_t tbl[11];
  int   cnt_we, cnt_rv;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]       = 16'(i * 37 + 3);
      model_mem[i] = 16'(i * 37 + 3);
    end
    mem[5] = 16'h1F41;
    model_mem[5] = 16'h1F41;

    //            en req daddr   hv haddr   hdata     we addr    wdata     rv rdata    lvl drop
    tbl[0]  = '{1, 1, 12'd5,   0, 12'd0,  16'h0,    0, 12'h005, 16'h0,    0, 16'h0,    0, 0};
    tbl[1]  = '{1, 0, 12'd0,   0, 12'd0,  16'h0,    0, 12'h005, 16'h0,    0, 16'h0,    0, 0};
    tbl[2]  = '{1, 0, 12'd0,   0, 12'd0,  16'h0,    0, 12'h005, 16'h0,    1, 16'h1F41, 0, 0};
    tbl[3]  = '{1, 0, 12'd0,   1, 12'h010,16'h0748, 0, 12'h005, 16'h0,    0, 16'h0,    1, 0};
    tbl[4]  = '{1, 0, 12'd0,   0, 12'd0,  16'h0,    1, 12'h010, 16'h0748, 0, 16'h0,    0, 0};
    tbl[5]  = '{1, 0, 12'd0,   0, 12'd0,  16'h0,    0, 12'h010, 16'h0,    0, 16'h0,    0, 0};
    tbl[6]  = '{1, 1, 12'h010, 0, 12'd0,  16'h0,    0, 12'h010, 16'h0,    0, 16'h0,    0, 0};
    tbl[7]  = '{1, 0, 12'd0,   0, 12'd0,  16'h0,    0, 12'h010, 16'h0,    0, 16'h0,    0, 0};
    tbl[8]  = '{1, 0, 12'd0,   0, 12'd0,  16'h0,    0, 12'h010, 16'h0,    1, 16'h0748, 0, 0};
    tbl[9]  = '{1, 0, 12'd0,   1, 12'd2400,16'h1234,0, 12'h010, 16'h0,    0, 16'h0,    0, 1};
    tbl[10] = '{1, 0, 12'd0,   0, 12'd0,  16'h0,    0, 12'h010, 16'h0,    0, 16'h0,    0, 0};

    // Reset state
    reset = 1;
    tick();
    tick();
    chk("rst_ready_low", host_ready, 0);
    reset = 0;
    #1;
    chk("rst_ready_high", host_ready, 1);

    // Directed table: fixed-latency read, host write then readback, out-of-range drop
    blank = 1;
    for (int i = 0; i < 11; i++) begin
      en = tbl[i].en; disp_req = tbl[i].req; disp_addr = tbl[i].daddr;
      host_valid = tbl[i].hv; host_addr = tbl[i].haddr; host_wdata = tbl[i].hdata;
      tick();
      chk($sformatf("tbl%0d_we", i), ram_we, tbl[i].we);
      chk($sformatf("tbl%0d_addr", i), ram_addr, tbl[i].addr);
      if (tbl[i].we) chk($sformatf("tbl%0d_wdata", i), ram_wdata, tbl[i].wdata);
      chk($sformatf("tbl%0d_rvalid", i), disp_rvalid, tbl[i].rvalid);
      if (tbl[i].rvalid) chk($sformatf("tbl%0d_rdata", i), disp_rdata, tbl[i].rdata);
      chk($sformatf("tbl%0d_level", i), fifo_level, tbl[i].level);
      chk($sformatf("tbl%0d_drop", i), host_drop, tbl[i].drop);
    end

    // Display held for 10 cycles while host pushes 5 writes: FIFO fills at 4, no writes issued
    cnt_we = 0;
    disp_req = 1;
    for (int i = 0; i < 10; i++) begin
      disp_addr  = 12'(i);
      host_valid = (i < 5);
      host_addr  = 12'h100 + 12'(i);
      host_wdata = 16'hA000 + 16'(i);
      tick();
      cnt_we += int'(ram_we);
      if (i == 3) chk("t3_ready_full", host_ready, 0);
    end
    chk("t3_no_we", cnt_we, 0);
    chk("t3_level4", fifo_level, 4);
    disp_req = 0; host_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t3_drain%0d_we", i), ram_we, 1);
      chk($sformatf("t3_drain%0d_addr", i), ram_addr, 12'h100 + 12'(i));
    end
    tick();
    chk("t3_empty", fifo_level, 0);

    // Blank-gated drain
    blank = 0; cnt_we = 0;
    for (int i = 0; i < 4; i++) begin
      host_valid = (i < 2);
      host_addr  = 12'h200 + 12'(i);
      host_wdata = 16'hB000 + 16'(i);
      tick();
      cnt_we += int'(ram_we);
    end
`ifdef TEXT_VRAM_BLANK_WR_EN
    chk("t5_active_we", cnt_we, 0);
`else
    chk("t5_active_we", cnt_we, 2);
`endif
    blank = 1; cnt_we = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      cnt_we += int'(ram_we);
    end
`ifdef TEXT_VRAM_BLANK_WR_EN
    chk("t5_blank_we", cnt_we, 2);
`else
    chk("t5_blank_we", cnt_we, 0);
`endif

    // Reset with 3 queued writes and a read in flight
    en = 0;
    for (int i = 0; i < 3; i++) begin
      host_valid = 1;
      host_addr  = 12'h300 + 12'(i);
      host_wdata = 16'hC000 + 16'(i);
      tick();
    end
    host_valid = 0;
    chk("t6_queued", fifo_level, 3);
    en = 1; disp_req = 1; disp_addr = 12'd7;
    tick();
    disp_req = 0; reset = 1;
    tick();
    reset = 0;
    chk("t6_level0", fifo_level, 0);
    cnt_we = 0; cnt_rv = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      cnt_we += int'(ram_we);
      cnt_rv += int'(disp_rvalid);
    end
    chk("t6_no_we", cnt_we, 0);
    chk("t6_no_rvalid", cnt_rv, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      en         = ($urandom_range(0, 9) != 0);
      blank      = ($urandom_range(0, 2) != 0);
      disp_req   = ($urandom_range(0, 1) == 1);
      disp_addr  = 12'($urandom_range(0, 4095));
      host_valid = ($urandom_range(0, 2) != 0);
      host_addr  = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(2400, 4095))
                                                : 12'($urandom_range(0, 2399));
      host_wdata = 16'($urandom);
      tick();
    end
    reset = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
